// File: rtl/stream_demux_1to2.sv
// One-to-two stream demultiplexer with a one-word register stage per channel.
// Each channel delivers its words in order and counts them.
module stream_demux_1to2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] data0_p1, data1_p1;
  logic             vld0_p1, vld1_p1;
  logic [CNT_W-1:0] cnt0_p1, cnt1_p1;

  logic in_xfer, ld0, ld1, xfer0, xfer1;

  // A channel's slot is free if empty or draining this cycle; in_valid is not consulted.
  assign in_ready = in_select ? (~vld1_p1 | out1_ready) : (~vld0_p1 | out0_ready);
  assign in_xfer  = in_valid & in_ready;
  assign ld0      = in_xfer & ~in_select;
  assign ld1      = in_xfer &  in_select;
  assign xfer0    = vld0_p1 & out0_ready;
  assign xfer1    = vld1_p1 & out1_ready;

  // Channel 0 register stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data0_p1 <= '0;
      vld0_p1  <= 1'b0;
      cnt0_p1  <= '0;
    end else begin
      if (ld0) data0_p1 <= in_data;
      vld0_p1 <= ld0 | (vld0_p1 & ~out0_ready);
      if (xfer0) cnt0_p1 <= cnt0_p1 + 1'b1;
    end
  end

  // Channel 1 register stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data1_p1 <= '0;
      vld1_p1  <= 1'b0;
      cnt1_p1  <= '0;
    end else begin
      if (ld1) data1_p1 <= in_data;
      vld1_p1 <= ld1 | (vld1_p1 & ~out1_ready);
      if (xfer1) cnt1_p1 <= cnt1_p1 + 1'b1;
    end
  end

  assign out0_data  = data0_p1;
  assign out0_valid = vld0_p1;
  assign out1_data  = data1_p1;
  assign out1_valid = vld1_p1;
  assign cnt0       = cnt0_p1;
  assign cnt1       = cnt1_p1;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: routing, backpressure, full-rate
// streaming, channel independence, counter wrap and reset mid-operation.
module tb_stream_demux_1to2;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_data;
  logic             in_select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = '0;
    in_select  = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    check("rst_out0_valid", 32'(out0_valid), 0);
    check("rst_out1_valid", 32'(out1_valid), 0);
    check("rst_cnt0", 32'(cnt0), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_out0_data", out0_data, 0);
    reset_n = 1'b1;
    in_select = 1'b0; #1;
    check("post_rst_ready_s0", 32'(in_ready), 1);
    in_select = 1'b1; #1;
    check("post_rst_ready_s1", 32'(in_ready), 1);

    // Basic routing to channel 1
    in_data = 32'hDEADBEEF; in_select = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("route_out1_valid", 32'(out1_valid), 1);
    check("route_out1_data", out1_data, 32'hDEADBEEF);
    check("route_out0_valid", 32'(out0_valid), 0);
    tick();
    check("route_cnt1", 32'(cnt1), 1);
    check("route_cnt0", 32'(cnt0), 0);
    check("route_out1_drained", 32'(out1_valid), 0);

    // Backpressure on channel 0
    out0_ready = 1'b0;
    in_data = 32'h1; in_select = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h2; #1;
    check("bp_ready_s0", 32'(in_ready), 0);
    in_select = 1'b1; #1;
    check("bp_ready_s1", 32'(in_ready), 1);
    in_select = 1'b0;
    tick();
    check("bp_hold_data", out0_data, 32'h1);
    check("bp_hold_valid", 32'(out0_valid), 1);
    check("bp_cnt0_stalled", 32'(cnt0), 0);
    out0_ready = 1'b1; #1;
    check("bp_ready_on_drain", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_second_data", out0_data, 32'h2);
    check("bp_second_valid", 32'(out0_valid), 1);
    check("bp_cnt0_one", 32'(cnt0), 1);
    tick();
    check("bp_cnt0_two", 32'(cnt0), 2);
    check("bp_empty", 32'(out0_valid), 0);

    // Full-rate pass-through on channel 0
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h10 + 32'(i); in_select = 1'b0; in_valid = 1'b1; #1;
      check($sformatf("rate_ready_%0d", i), 32'(in_ready), 1);
      tick();
      check($sformatf("rate_data_%0d", i), out0_data, 32'h10 + 32'(i));
      check($sformatf("rate_valid_%0d", i), 32'(out0_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    check("rate_cnt0", 32'(cnt0), 10);

    // Channel 1 proceeds while channel 0 is stalled
    out0_ready = 1'b0;
    in_data = 32'h33; in_select = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'hA5; in_select = 1'b1; out1_ready = 1'b1; #1;
    check("indep_ready_s1", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("indep_out1_data", out1_data, 32'hA5);
    check("indep_out1_valid", 32'(out1_valid), 1);
    check("indep_out0_data", out0_data, 32'h33);
    check("indep_out0_valid", 32'(out0_valid), 1);
    tick();
    check("indep_cnt1", 32'(cnt1), 2);
    check("indep_cnt0", 32'(cnt0), 10);

    // Reset discards the held channel-0 word uncounted
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst2_out0_valid", 32'(out0_valid), 0);
    check("rst2_cnt0", 32'(cnt0), 0);
    check("rst2_cnt1", 32'(cnt1), 0);

    // Counter wrap on channel 1 (CNT_W=4)
    out1_ready = 1'b1; in_select = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in_data = 32'(i); in_valid = 1'b1;
      tick();
      if (i == 16) check("wrap_cnt_15", 32'(cnt1), 15);
      if (i == 17) check("wrap_cnt_16", 32'(cnt1), 0);
    end
    in_valid = 1'b0;
    tick();
    check("wrap_cnt_17", 32'(cnt1), 1);

    // Reset mid-operation with both channels full and an input pending
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_data = 32'h55; in_select = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 32'h66; in_select = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_rst_out0_valid", 32'(out0_valid), 1);
    check("pre_rst_out1_valid", 32'(out1_valid), 1);
    reset_n = 1'b0; in_valid = 1'b1; in_select = 1'b0; in_data = 32'h77; out0_ready = 1'b1;
    tick();
    reset_n = 1'b1; in_valid = 1'b0; out0_ready = 1'b0;
    check("midrst_out0_valid", 32'(out0_valid), 0);
    check("midrst_out1_valid", 32'(out1_valid), 0);
    check("midrst_cnt0", 32'(cnt0), 0);
    check("midrst_cnt1", 32'(cnt1), 0);
    check("midrst_out0_data", out0_data, 0);
    in_select = 1'b0; #1;
    check("midrst_ready_s0", 32'(in_ready), 1);
    in_select = 1'b1; #1;
    check("midrst_ready_s1", 32'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
